// File: rtl/adc_ad768x_seq.sv
// AD7682/AD7689 scan sequencer with its own SPI engine.
// One CFG write and one result read per frame; two priming frames per scan.
module adc_ad768x_seq #(
  parameter int          NUM_CH     = 4,
  parameter logic [13:0] CFG_BASE   = 14'h3C49,
  parameter int          CLK_DIV    = 2,
  parameter int          CONV_CLKS  = 300,
  parameter int          CYCLE_CLKS = 375
) (
  input  logic                 clk,
  input  logic                 resetL,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 abort,
  output logic [NUM_CH*16-1:0] adc_data,
  output logic                 ch_valid,
  output logic [2:0]           ch_idx,
  output logic [15:0]          ch_data,
  output logic                 seq_done,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 MISO,
  output logic                 MOSI,
  output logic                 SCK,
  output logic                 SS_0
);

  localparam int FCW = $clog2(CYCLE_CLKS + 1);
  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [3:0] LAST_F = 4'(NUM_CH + 1);

  typedef enum logic [2:0] {
    IDLE, CONV, XFER, STORE, GAP
  } state_t;

  state_t state, state_n;

  logic [2:0]     sync;
  logic           start_edge;
  logic [FCW-1:0] fcnt;
  logic [3:0]     frame;
  logic [DW-1:0]  dcnt;
  logic [4:0]     hcnt;
  logic [15:0]    tx_sh;
  logic [15:0]    rx_sh;
  logic           cont_q;
  logic           abort_q;

  logic           div_tick;
  logic           conv_end;
  logic           frame_end;
  logic           xfer_end;
  logic           last_f;
  logic           stop;
  logic           seq_start;
  logic [2:0]     tx_ch;
  logic [13:0]    cfg;
  logic [15:0]    tx_word;

  assign start_edge = sync[1] & ~sync[2];
  assign div_tick   = dcnt == DW'(CLK_DIV - 1);
  assign conv_end   = fcnt == FCW'(CONV_CLKS - 1);
  assign frame_end  = fcnt == FCW'(CYCLE_CLKS - 1);
  assign xfer_end   = (state == XFER) && div_tick && (hcnt == 5'd31);
  assign last_f     = frame == LAST_F;
  assign stop       = abort | abort_q;
  assign seq_start  = (state_n == CONV) &&
                      ((state == IDLE) || (state == GAP && last_f));
  assign MOSI       = tx_sh[15];

  // CFG word for this frame; frames past the last channel send a dummy ch 0
  always_comb begin
    tx_ch = 3'd0;
    if (frame < 4'(NUM_CH)) tx_ch = frame[2:0];
    cfg = CFG_BASE;
    cfg[9:7] = tx_ch;
    tx_word = {cfg, 2'b00};
  end

  // Next-state decode; abort only acts at a frame boundary once running
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start_edge && !abort) state_n = CONV;
      CONV:  if (conv_end) state_n = XFER;
      XFER:  if (xfer_end) state_n = STORE;
      STORE: state_n = GAP;
      GAP: begin
        if (frame_end) begin
          if (stop || (last_f && !cont_q)) state_n = IDLE;
          else state_n = CONV;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and start synchroniser
  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      state <= IDLE;
      sync  <= '0;
    end else begin
      state <= state_n;
      sync  <= {sync[1:0], start};
    end
  end

  // Frame timing, frame index, continuous and abort latches
  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      fcnt    <= '0;
      frame   <= '0;
      cont_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      if (state_n == CONV && state != CONV) fcnt <= '0;
      else if (state_n != IDLE) fcnt <= fcnt + FCW'(1);
      if (seq_start) frame <= '0;
      else if (state == GAP && frame_end) frame <= frame + 4'd1;
      if (abort) cont_q <= 1'b0;
      else if (seq_start) cont_q <= continuous;
      if (state_n == IDLE) abort_q <= 1'b0;
      else if (abort) abort_q <= 1'b1;
    end
  end

  // SPI mode 0 engine: MOSI shifts on SCK fall, MISO sampled on SCK rise
  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      SS_0  <= 1'b1;
      SCK   <= 1'b0;
      dcnt  <= '0;
      hcnt  <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
    end else if (state == CONV && conv_end) begin
      SS_0  <= 1'b0;
      SCK   <= 1'b0;
      dcnt  <= '0;
      hcnt  <= '0;
      tx_sh <= tx_word;
    end else if (state == XFER) begin
      if (div_tick) begin
        dcnt <= '0;
        hcnt <= hcnt + 5'd1;
        if (!SCK) begin
          SCK   <= 1'b1;
          rx_sh <= {rx_sh[14:0], MISO};
        end else begin
          SCK <= 1'b0;
          if (hcnt == 5'd31) begin
            tx_sh <= '0;
            SS_0  <= 1'b1;
          end else begin
            tx_sh <= {tx_sh[14:0], 1'b0};
          end
        end
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

  // Result publishing; priming frames 0 and 1 are dropped
  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      adc_data <= '0;
      ch_valid <= 1'b0;
      ch_idx   <= '0;
      ch_data  <= '0;
      seq_done <= 1'b0;
    end else begin
      ch_valid <= 1'b0;
      seq_done <= 1'b0;
      if (xfer_end && frame >= 4'd2) begin
        ch_valid <= 1'b1;
        ch_idx   <= 3'(frame - 4'd2);
        ch_data  <= rx_sh;
        for (int k = 0; k < NUM_CH; k++) begin
          if (frame == 4'(k + 2)) adc_data[16*k +: 16] <= rx_sh;
        end
      end
      if (state == STORE) seq_done <= last_f & ~stop;
    end
  end

  // Busy flag and sticky overrun
  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      busy <= state_n != IDLE;
      if (start_edge) begin
        if (state != IDLE) overrun <= 1'b1;
        else if (!abort) overrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/adc_ad768x_seq.md
Name: adc_ad768x_seq

Overview:
Parametrised sequencer for AD768x-family SAR ADCs (AD7682/AD7689) with its own SPI engine. Each frame writes one CFG word and reads one result. It scans NUM_CH channels per sequence, single-shot or continuous, and publishes per-channel results to the controller. It handles the ADC's two-frame configuration pipeline internally by discarding priming frames.

Parameters:
NUM_CH, 4, channels scanned per sequence, 1..8, channel k maps to ADC input k
CFG_BASE, 14'h3C49, CFG word template; bits [9:7] replaced per frame by channel index
CLK_DIV, 2, SCK half-period in clk cycles, >=1
CONV_CLKS, 300, clk cycles SS_0 stays high at frame start (conversion time)
CYCLE_CLKS, 375, frame period in clk cycles; must be >= CONV_CLKS + 32*CLK_DIV + 2

Ports:
clk  in  1  system clock (75 MHz)
resetL  in  1  reset
start  in  1  capture request, rising edge detected through a 2-flop synchroniser
continuous  in  1  1 = restart the sequence automatically after seq_done; sampled at each sequence start
abort  in  1  synchronous stop request
adc_data  out  NUM_CH*16  channel k result in bits [16k+15:16k]
ch_valid  out  1  one-cycle strobe when a result is stored
ch_idx  out  3  channel index of the current ch_valid
ch_data  out  16  result qualified by ch_valid
seq_done  out  1  one-cycle pulse after the last channel is stored
busy  out  1  high whenever the state is not IDLE
overrun  out  1  sticky; set when a start edge arrives while busy; cleared by the next start edge accepted in IDLE
MISO  in  1  ADC SDO
MOSI  out  1  ADC DIN
SCK  out  1  SPI clock, idle low
SS_0  out  1  ADC CNV

Behaviour:
- Reset: resetL is asynchronous, active-low; clock is clk. All outputs go to 0 on reset, except SS_0, which resets to 1. State goes to IDLE.
- States: IDLE -> CONV -> XFER -> STORE -> GAP -> CONV or IDLE.
- A frame counter runs 0..CYCLE_CLKS-1 from the frame start.
- CONV: SS_0 = 1 for CONV_CLKS cycles, then move to XFER with SS_0 = 0.
- XFER: 16 SPI bits in mode 0, MSB first.
  - MOSI is updated on the SCK falling edge. Bit 15 is valid when SS_0 falls.
  - MISO is sampled on the SCK rising edge.
  - TX word is {CFG_BASE with [9:7] = tx_ch, 2'b00}.
  - XFER lasts 32*CLK_DIV cycles. SCK ends low. MOSI returns to 0.
- STORE: lasts 1 cycle; SS_0 goes to 1.
  - Frames 0 and 1 of a sequence only prime the ADC; their results are discarded with no strobe.
  - Frame f >= 2 stores channel f-2 into the adc_data slice, with ch_valid = 1, ch_idx = f-2, ch_data = result, all in the same cycle.
- GAP: wait until the frame counter reaches CYCLE_CLKS-1.
- Channel selection per frame: tx_ch = f for f < NUM_CH, otherwise 0 (dummy).
- Frames per sequence = NUM_CH + 2. The final stored channel is NUM_CH-1.
- After the last STORE, seq_done pulses in the cycle following the final ch_valid.
- Then the next state is CONV if continuous is latched, otherwise IDLE.
- A continuous restart begins again at frame 0, including the two priming frames.
- In the continuous restart, the frame start falls exactly CYCLE_CLKS cycles after the previous frame start.
- Latency: the first ch_valid occurs at 2*CYCLE_CLKS + CONV_CLKS + 32*CLK_DIV + 1 cycles after the synchronised start edge.
- start edge while busy: ignored, and overrun is set.
- start and abort in the same cycle: abort wins.
- abort:
  - Takes effect at the next frame boundary, or at once if the state is IDLE.
  - The current frame completes, including its STORE.
  - Then go to IDLE with no seq_done.
  - The continuous latch is cleared.
- NUM_CH = 1: 3 frames per sequence, one result.
- Asynchronous reset mid-frame: SS_0 = 1 and SCK = 0 immediately; partial data is discarded; adc_data is cleared.
- adc_data slices hold their value until overwritten.

Test Plan:
- NUM_CH=4, ADC model returning 16'h1000+ch; one start pulse -> four ch_valid strobes, ch_idx 0..3, data 1000/1001/1002/1003; one seq_done; busy falls; 6 frames of 375 clk each.
- MOSI capture per frame -> CFG [9:7] sequence 0,1,2,3,0,0; each word = CFG_BASE<<2 with the channel field substituted; SCK count 16 per frame; SCK low whenever SS_0 = 1.
- continuous=1 -> second sequence frame 0 starts exactly 375 clk after the last frame start; abort raised mid-XFER of frame 3 -> frame 3 still stores channel 1, then IDLE, no seq_done, busy = 0.
- start edge during busy -> overrun = 1 and the sequence is not disturbed; next start in IDLE -> overrun clears and a new sequence runs.
- NUM_CH=1, CLK_DIV=1, CYCLE_CLKS=340 -> exactly one ch_valid (idx 0), first ch_valid at 2*340+300+33 = 1013 cycles after the synchronised start edge.
- resetL asserted mid-XFER -> SS_0 = 1, SCK = 0, adc_data = 0 asynchronously; after release, start runs a clean sequence.
